// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared pipeline definitions for the hazard controller:
//               FSM state encoding, forwarding-select encodings and a small
//               helper that decides whether a write-back stage can forward.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    // A stage can supply an operand only if it writes a real register
    // (x0 is hard-wired to zero and must never be forwarded).
    function automatic logic wb_hit(input logic       wen,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs);
        return wen && (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Operand forwarding select for one ALU source. The youngest
//               producer (EX/MEM) wins over the older one (MEM/WB).
// Ports       : rs_ex_i        - source register held in ID/EX
//               rd_exmem_i     - EX/MEM destination, regwen_exmem_i its enable
//               rd_memwb_i     - MEM/WB destination, regwen_memwb_i its enable
//               fwd_o          - FWD_RF / FWD_EXMEM / FWD_MEMWB
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_ex_i,
    input  logic [4:0] rd_exmem_i,
    input  logic       regwen_exmem_i,
    input  logic [4:0] rd_memwb_i,
    input  logic       regwen_memwb_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (wb_hit(regwen_exmem_i, rd_exmem_i, rs_ex_i)) begin
            fwd_o = FWD_EXMEM;
        end else if (wb_hit(regwen_memwb_i, rd_memwb_i, rs_ex_i)) begin
            fwd_o = FWD_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard controller for a 5-stage pipeline. Generates stage
//               enables/flushes for load-use stalls, taken branches and data
//               memory wait states, detects memory timeouts, selects ALU
//               operand forwarding and counts stalled cycles.
// Ports       : clk, rst_n             - pipeline clock (state on negedge),
//                                        async active-low reset
//               rs*_id, rs*_used_id    - sources of the ID instruction
//               rs*_ex                 - sources held in ID/EX
//               rd_idex/exmem/memwb    - stage destinations
//               ld_idex                - ID/EX holds a load
//               regwen_exmem/memwb     - stage write enables
//               br_taken_ex            - branch/jump taken in EX
//               mem_busy               - data memory not ready
//               pc_en..exmem_en        - stage register load enables
//               ifid_flush/idex_flush  - insert bubble
//               fwd_a/fwd_b            - operand forwarding selects
//               mem_timeout            - sticky timeout error
//               stall_cycles           - saturating stalled-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic [4:0]  rs1_ex,
    input  logic [4:0]  rs2_ex,
    input  logic [4:0]  rd_idex,
    input  logic [4:0]  rd_exmem,
    input  logic [4:0]  rd_memwb,
    input  logic        ld_idex,
    input  logic        regwen_exmem,
    input  logic        regwen_memwb,
    input  logic        br_taken_ex,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [15:0]       stall_q, stall_d;

    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
    logic ifid_flush_c, idex_flush_c, timeout_c;
    logic lu_hazard;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign lu_hazard = ld_idex && (rd_idex != REG_ZERO) &&
                       ((rs1_used_id && (rs1_id == rd_idex)) ||
                        (rs2_used_id && (rs2_id == rd_idex)));

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        wait_inc     = wait_q + WAIT_W'(1);
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        timeout_c    = 1'b0;

        case (state_q)
            ST_ERROR: begin
                pc_en_c    = 1'b0;
                ifid_en_c  = 1'b0;
                idex_en_c  = 1'b0;
                exmem_en_c = 1'b0;
                timeout_c  = 1'b1;
            end
            // RUN, LU_STALL and MEM_WAIT share one event priority; they only
            // differ in wait counting and whether a new bubble is allowed.
            default: begin
                if (mem_busy) begin
                    pc_en_c    = 1'b0;
                    ifid_en_c  = 1'b0;
                    idex_en_c  = 1'b0;
                    exmem_en_c = 1'b0;
                    if (state_q == ST_MEM_WAIT) begin
                        wait_d  = wait_inc;
                        state_d = (wait_inc >= WAIT_MAX) ? ST_ERROR : ST_MEM_WAIT;
                    end else begin
                        // The cycle that first sees busy is wait cycle 1.
                        wait_d  = WAIT_W'(1);
                        state_d = ST_MEM_WAIT;
                    end
                end else begin
                    wait_d  = '0;
                    state_d = ST_RUN;
                    if (br_taken_ex) begin
                        ifid_flush_c = 1'b1;
                        idex_flush_c = 1'b1;
                    end else if (lu_hazard && (state_q != ST_LU_STALL)) begin
                        // The hazard seen right after a bubble is the same
                        // instruction pair already separated; no second bubble.
                        pc_en_c      = 1'b0;
                        ifid_en_c    = 1'b0;
                        idex_flush_c = 1'b1;
                        state_d      = ST_LU_STALL;
                    end
                end
            end
        endcase
    end

    assign stall_d = (!pc_en_c && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    fwd_unit u_fwd_a (
        .rs_ex_i        (rs1_ex),
        .rd_exmem_i     (rd_exmem),
        .regwen_exmem_i (regwen_exmem),
        .rd_memwb_i     (rd_memwb),
        .regwen_memwb_i (regwen_memwb),
        .fwd_o          (fwd_a_c)
    );

    fwd_unit u_fwd_b (
        .rs_ex_i        (rs2_ex),
        .rd_exmem_i     (rd_exmem),
        .regwen_exmem_i (regwen_exmem),
        .rd_memwb_i     (rd_memwb),
        .regwen_memwb_i (regwen_memwb),
        .fwd_o          (fwd_b_c)
    );

    // While reset is held the pipeline is frozen and filled with bubbles.
    assign pc_en        = rst_n & pc_en_c;
    assign ifid_en      = rst_n & ifid_en_c;
    assign idex_en      = rst_n & idex_en_c;
    assign exmem_en     = rst_n & exmem_en_c;
    assign ifid_flush   = ~rst_n | ifid_flush_c;
    assign idex_flush   = ~rst_n | idex_flush_c;
    assign fwd_a        = rst_n ? fwd_a_c : FWD_RF;
    assign fwd_b        = rst_n ? fwd_b_c : FWD_RF;
    assign mem_timeout  = rst_n & timeout_c;
    assign stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_id, rs2_id, rs1_ex, rs2_ex;
    logic        rs1_used_id, rs2_used_id;
    logic [4:0]  rd_idex, rd_exmem, rd_memwb;
    logic        ld_idex, regwen_exmem, regwen_memwb, br_taken_ex, mem_busy;
    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state: consecutive busy cycles, a dead (timed-out)
    // flag, whether the previous cycle inserted a load-use bubble, stalls.
    bit       m_dead;
    int       m_busy_run;
    bit       m_bubbled;
    int       m_stalls;
    bit       m_lu;
    bit [3:0] m_en;   // {pc, ifid, idex, exmem}
    bit [1:0] m_fl;   // {ifid, idex}
    bit       m_tmo;
    bit [1:0] m_fa, m_fb;

    pipe_hazard_ctrl #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_used_id  (rs1_used_id),
        .rs2_used_id  (rs2_used_id),
        .rs1_ex       (rs1_ex),
        .rs2_ex       (rs2_ex),
        .rd_idex      (rd_idex),
        .rd_exmem     (rd_exmem),
        .rd_memwb     (rd_memwb),
        .ld_idex      (ld_idex),
        .regwen_exmem (regwen_exmem),
        .regwen_memwb (regwen_memwb),
        .br_taken_ex  (br_taken_ex),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [1:0] fwd_ref(input logic [4:0] rs);
        if (regwen_exmem && rd_exmem != 0 && rd_exmem == rs) return 2'b01;
        if (regwen_memwb && rd_memwb != 0 && rd_memwb == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_idex, rd_exmem, rd_memwb} = '0;
        {rs1_used_id, rs2_used_id, ld_idex, regwen_exmem, regwen_memwb} = '0;
        br_taken_ex = 1'b0;
        mem_busy    = 1'b0;
    endtask

    task automatic rand_inputs();
        // Small register range so hazards and forwarding hits are frequent.
        rs1_id       = 5'($urandom_range(0, 3));
        rs2_id       = 5'($urandom_range(0, 3));
        rs1_ex       = 5'($urandom_range(0, 3));
        rs2_ex       = 5'($urandom_range(0, 3));
        rd_idex      = 5'($urandom_range(0, 3));
        rd_exmem     = 5'($urandom_range(0, 3));
        rd_memwb     = 5'($urandom_range(0, 3));
        rs1_used_id  = 1'($urandom_range(0, 1));
        rs2_used_id  = 1'($urandom_range(0, 1));
        ld_idex      = 1'($urandom_range(0, 1));
        regwen_exmem = 1'($urandom_range(0, 1));
        regwen_memwb = 1'($urandom_range(0, 1));
        br_taken_ex  = ($urandom_range(0, 7) == 0);
        mem_busy     = ($urandom_range(0, 4) == 0);
    endtask

    task automatic model_eval();
        bit lu;
        lu = ld_idex && rd_idex != 0 &&
             ((rs1_used_id && rs1_id == rd_idex) || (rs2_used_id && rs2_id == rd_idex));
        m_fl  = 2'b00;
        m_tmo = 1'b0;
        m_lu  = 1'b0;
        if (m_dead) begin
            m_en  = 4'b0000;
            m_tmo = 1'b1;
        end else if (mem_busy) begin
            m_en = 4'b0000;
        end else if (br_taken_ex) begin
            m_en = 4'b1111;
            m_fl = 2'b11;
        end else if (lu && !m_bubbled) begin
            m_en = 4'b0011;
            m_fl = 2'b01;
            m_lu = 1'b1;
        end else begin
            m_en = 4'b1111;
        end
        m_fa = fwd_ref(rs1_ex);
        m_fb = fwd_ref(rs2_ex);
    endtask

    task automatic model_step();
        if (!m_en[3] && m_stalls < 65535) m_stalls++;
        if (!m_dead) begin
            if (mem_busy) begin
                m_busy_run++;
                m_bubbled = 1'b0;
                if (m_busy_run >= TMO) m_dead = 1'b1;
            end else begin
                m_busy_run = 0;
                m_bubbled  = m_lu;
            end
        end
    endtask

    // Called just after a rising edge with inputs already applied; checks the
    // combinational outputs mid-cycle, then advances the model on the falling
    // (active) edge and returns at the next rising edge.
    task automatic tick();
        #1;
        model_eval();
        check_val("enables", {pc_en, ifid_en, idex_en, exmem_en}, m_en);
        check_val("flushes", {ifid_flush, idex_flush}, m_fl);
        check_val("fwd_a", fwd_a, m_fa);
        check_val("fwd_b", fwd_b, m_fb);
        check_val("mem_timeout", mem_timeout, m_tmo);
        check_val("stall_cycles", stall_cycles, m_stalls);
        @(negedge clk);
        model_step();
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rand_inputs();
        #1;
        check_val("rst_enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
        check_val("rst_flushes", {ifid_flush, idex_flush}, 2'b11);
        check_val("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        check_val("rst_timeout", mem_timeout, 1'b0);
        check_val("rst_stall", stall_cycles, 16'd0);
        m_dead     = 1'b0;
        m_busy_run = 0;
        m_bubbled  = 1'b0;
        m_stalls   = 0;
        @(negedge clk);
        @(posedge clk);
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        do_reset();

        // Load-use hazard: one bubble, then normal flow even though the
        // hazard inputs persist.
        ld_idex = 1'b1; rd_idex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
        #1;
        check_val("lu_pc_en", pc_en, 1'b0);
        check_val("lu_idex_flush", idex_flush, 1'b1);
        tick();
        #1;
        check_val("lu_next_pc_en", pc_en, 1'b1);
        check_val("lu_next_flush", idex_flush, 1'b0);
        check_val("lu_stall_cnt", stall_cycles, 16'd1);
        tick();

        // Branch together with the same hazard: flush wins, no stall.
        do_reset();
        ld_idex = 1'b1; rd_idex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
        br_taken_ex = 1'b1;
        #1;
        check_val("br_lu_flushes", {ifid_flush, idex_flush}, 2'b11);
        check_val("br_lu_pc_en", pc_en, 1'b1);
        tick();
        br_taken_ex = 1'b0; ld_idex = 1'b0;
        tick();
        check_val("br_lu_stall_cnt", stall_cycles, 16'd0);

        // Forwarding priority.
        rd_exmem = 5'd7; rd_memwb = 5'd7; regwen_exmem = 1'b1; regwen_memwb = 1'b1;
        rs2_ex = 5'd7;
        #1;
        check_val("fwd_exmem", fwd_b, 2'b01);
        tick();
        rd_exmem = 5'd0;
        #1;
        check_val("fwd_memwb", fwd_b, 2'b10);
        tick();
        rs2_ex = 5'd0; rd_memwb = 5'd0;
        #1;
        check_val("fwd_rf", fwd_b, 2'b00);
        tick();

        // Memory wait of three cycles, normal flow on the fourth.
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("mw_enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        check_val("mw_resume", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
        check_val("mw_stall_cnt", stall_cycles, 16'd3);
        tick();

        // Timeout after TMO busy cycles; sticky until reset.
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            #1;
            check_val("tmo_pending", mem_timeout, 1'b0);
            tick();
        end
        #1;
        check_val("tmo_set", mem_timeout, 1'b1);
        tick();
        mem_busy = 1'b0;
        #1;
        check_val("tmo_sticky", mem_timeout, 1'b1);
        check_val("tmo_enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
        tick();
        do_reset();

        // Randomized traffic with occasional resets (also mid-stall/wait).
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 79) == 0 || (m_dead && $urandom_range(0, 3) == 0)) begin
                do_reset();
            end else begin
                rand_inputs();
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
